// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain: parametrised chain of STAGES payload registers with a
// valid/ready handshake. Empty stages always accept (bubble collapse), any subset
// of stages can be squashed, and the block reports registered occupancy plus a
// saturating count of cycles in which the output was stalled.
module pipeline_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         in_flush,
  input  logic [STAGES-1:0]            in_flush_mask,
  output logic [$clog2(STAGES+1)-1:0]  out_count,
  output logic [CNT_W-1:0]             out_stall_cycles
);

  localparam int CW = $clog2(STAGES + 1);

  // Number of set bits in a stage-valid vector.
  function automatic logic [CW-1:0] popcnt(input logic [STAGES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  logic [STAGES-1:0]             r_vld;
  logic [STAGES-1:0][DATA_W-1:0] r_data;
  logic [CW-1:0]                 r_count;
  logic [CNT_W-1:0]              r_stall;

  logic [STAGES-1:0]             w_rdy;
  logic [STAGES-1:0]             w_up_vld;
  logic [STAGES-1:0][DATA_W-1:0] w_up_data;
  logic [STAGES-1:0]             w_kill;
  logic [STAGES-1:0]             w_nxt_vld;
  logic                          w_in_ready;

  // A stage can take a new beat if it is empty or its own occupant moves on.
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES-1] = !r_vld[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) w_rdy[i] = !r_vld[i] || w_rdy[i+1];
  end

  // Flush blocks the input outright; reset also holds the input off.
  assign w_in_ready = w_rdy[0] && !in_flush && rst_n;

  // What each stage would see from its upstream neighbour this cycle.
  always_comb begin
    w_up_vld     = '0;
    w_up_data    = '0;
    w_up_vld[0]  = in_valid && w_in_ready;
    w_up_data[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_up_vld[i]  = r_vld[i-1];
      w_up_data[i] = r_data[i-1];
    end
  end

  // Advance first, then squash; a beat leaving the last stage is already gone.
  always_comb begin
    w_kill    = in_flush_mask | {STAGES{in_flush}};
    w_nxt_vld = '0;
    for (int i = 0; i < STAGES; i++)
      w_nxt_vld[i] = (w_rdy[i] ? w_up_vld[i] : r_vld[i]) && !w_kill[i];
  end

  // Valid bits, occupancy and the stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      r_vld   <= w_nxt_vld;
      r_count <= popcnt(w_nxt_vld);
      if (r_vld[STAGES-1] && !out_ready) r_stall <= sat_inc(r_stall);
    end
  end

  // Payload moves only with a valid beat; squashed stages keep stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++)
        if (w_rdy[i] && w_up_vld[i]) r_data[i] <= w_up_data[i];
    end
  end

  assign in_ready         = w_in_ready;
  assign out_valid        = r_vld[STAGES-1];
  assign out_data         = r_data[STAGES-1];
  assign out_count        = r_count;
  assign out_stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed bench for pipeline_stage_chain (DATA_W=32, STAGES=3, CNT_W=16).
module tb_pipeline_stage_chain;

  localparam int DATA_W = 32;
  localparam int STAGES = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              in_flush;
  logic [STAGES-1:0] in_flush_mask;
  logic [1:0]        out_count;
  logic [CNT_W-1:0]  out_stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .in_flush         (in_flush),
    .in_flush_mask    (in_flush_mask),
    .out_count        (out_count),
    .out_stall_cycles (out_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    in_flush = 1'b0; in_flush_mask = '0;

    // Reset held two cycles with a beat offered
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_stall", 32'(out_stall_cycles), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x10..0x14
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h10 + 32'(k);
      #1;
      chk("str_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (k >= 2) begin
        chk("str_out_valid", 32'(out_valid), 32'd1);
        chk("str_out_data", out_data, 32'h10 + 32'(k - 2));
        chk("str_count", 32'(out_count), 32'd3);
      end else begin
        chk("str_lat_valid", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    tick(); chk("str_d13", out_data, 32'h13); chk("str_c2", 32'(out_count), 32'd2);
    tick(); chk("str_d14", out_data, 32'h14); chk("str_c1", 32'(out_count), 32'd1);
    tick(); chk("str_empty", 32'(out_valid), 32'd0); chk("str_c0", 32'(out_count), 32'd0);

    // Backpressure: A,B,C accepted, D held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hA1 + 32'(k);
      #1;
      chk("bp_accept", 32'(in_ready), 32'd1);
      tick();
    end
    chk("bp_count", 32'(out_count), 32'd3);
    chk("bp_stall0", 32'(out_stall_cycles), 32'd0);
    in_data = 32'hA4;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("bp_d_blocked", 32'(in_ready), 32'd0);
      tick();
      chk("bp_stall_inc", 32'(out_stall_cycles), 32'(k));
      chk("bp_hold_a", out_data, 32'hA1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_out_a", out_data, 32'hA1);
    tick(); in_valid = 1'b0;
    chk("bp_out_b", out_data, 32'hA2);
    tick(); chk("bp_out_c", out_data, 32'hA3);
    tick(); chk("bp_out_d", out_data, 32'hA4); chk("bp_d_valid", 32'(out_valid), 32'd1);
    tick(); chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_stall_kept", 32'(out_stall_cycles), 32'd3);

    // Bubble collapse: A, two idle cycles, B, one more cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'hB2; tick();
    in_valid = 1'b0; tick();
    chk("bub_count", 32'(out_count), 32'd2);
    chk("bub_out_a", out_data, 32'hB1);
    chk("bub_stall", 32'(out_stall_cycles), 32'd5);
    out_ready = 1'b1;
    tick(); chk("bub_out_b", out_data, 32'hB2); chk("bub_b_valid", 32'(out_valid), 32'd1);
    tick(); chk("bub_empty", 32'(out_valid), 32'd0);

    // Selective flush of stage 1
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hC1 + 32'(k); tick();
    end
    in_valid = 1'b0;
    chk("sf_count3", 32'(out_count), 32'd3);
    out_ready = 1'b1; in_flush_mask = 3'b010;
    #1;
    chk("sf_out_a", out_data, 32'hC1);
    tick(); in_flush_mask = '0;
    chk("sf_out_b", out_data, 32'hC2);
    chk("sf_count1", 32'(out_count), 32'd1);
    tick();
    chk("sf_c_squashed", 32'(out_valid), 32'd0);
    chk("sf_count0", 32'(out_count), 32'd0);

    // Full flush on empty chain with a beat offered
    in_flush = 1'b1; in_valid = 1'b1; in_data = 32'hEE;
    #1;
    chk("ff_in_ready", 32'(in_ready), 32'd0);
    tick(); in_flush = 1'b0; in_valid = 1'b0;
    chk("ff_out_valid", 32'(out_valid), 32'd0);
    chk("ff_count", 32'(out_count), 32'd0);
    tick(); tick();
    chk("ff_not_taken", 32'(out_valid), 32'd0);

    // Full flush of a full stalled chain
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hD1 + 32'(k); tick();
    end
    in_valid = 1'b0;
    chk("ff2_full", 32'(out_count), 32'd3);
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    chk("ff2_count", 32'(out_count), 32'd0);
    chk("ff2_valid", 32'(out_valid), 32'd0);
    chk("ff2_stall", 32'(out_stall_cycles), 32'd6);

    // Reset clears counter, then saturation with one stalled beat
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst2_stall", 32'(out_stall_cycles), 32'd0);
    in_valid = 1'b1; in_data = 32'h5A; tick(); in_valid = 1'b0;
    tick(); tick();
    chk("sat_valid", 32'(out_valid), 32'd1);
    repeat (65534) tick();
    chk("sat_pre", 32'(out_stall_cycles), 32'd65534);
    repeat (5000) tick();
    chk("sat_full", 32'(out_stall_cycles), 32'hFFFF);
    chk("sat_data", out_data, 32'h5A);

    // Reset mid-stream, overriding a flush request
    in_flush = 1'b1; rst_n = 1'b0; tick(); in_flush = 1'b0;
    chk("rst3_valid", 32'(out_valid), 32'd0);
    chk("rst3_data", out_data, 32'd0);
    chk("rst3_stall", 32'(out_stall_cycles), 32'd0);
    chk("rst3_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_chain.md
Name: pipeline_stage_chain

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX and EX/WB pipeline buffers: a chain of STAGES registers carrying a DATA_W-bit payload.
- Adds what the fixed buffers lack: valid/ready handshake with backpressure (stall), bubble collapsing, selective per-stage flush (branch/jump squash), occupancy reporting and a stall-cycle counter.
- Sits between any two pipeline stages of the core; control fields and data are packed into the payload by the instantiator.

Parameters:
DATA_W, 32, payload width in bits (1..256)
STAGES, 3, number of register stages (1..8)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
in_valid  in  1  upstream beat offered
in_ready  out  1  chain accepts a beat this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  last stage holds a beat
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  last-stage payload
in_flush  in  1  squash all stages, block input
in_flush_mask  in  STAGES  squash selected stages (bit 0 = stage nearest input)
out_count  out  clog2(STAGES+1)  number of valid stages (registered)
out_stall_cycles  out  CNT_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- State: valid_q[i], data_q[i], i = 0..STAGES-1; stage STAGES-1 drives out_valid/out_data.
- Ready chain (combinational): rdy[S-1] = !valid_q[S-1] || out_ready; rdy[i] = !valid_q[i] || rdy[i+1].
- in_ready = rdy[0] && !in_flush && rst_n.
- Transfer: beat accepted when in_valid && in_ready; downstream transfer when out_valid && out_ready.
- On each edge, for every stage with rdy[i]=1: valid_q[i] takes the upstream valid (in_valid && in_ready for stage 0). data_q[i] loads only when that upstream valid is 1, otherwise holds.
- Stages with rdy[i]=0 hold valid and data.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Flush, applied after the move: next_valid[i] &= ~in_flush_mask[i]. in_flush is equivalent to an all-ones mask and also forces in_ready=0, so no beat is accepted that cycle.
- A beat transferred out of the last stage in the same cycle as a flush is delivered, not squashed.
- Masked stages keep stale data_q; only the valid bit clears.
- Latency: a beat accepted at edge t appears on out_valid after edge t+STAGES-1, i.e. STAGES cycles from offer to output on an empty chain. Throughput is 1 beat/cycle when out_ready=1.
- Ordering: strict FIFO; no loss or duplication except explicit flush.
- out_count: registered popcount of next_valid after flush; updated every edge.
- out_stall_cycles: +1 on every edge where out_valid && !out_ready. Saturates at 2^CNT_W-1. Cleared only by reset.
- Reset (rst_n=0 at edge):
  - all valid_q=0, data_q=0, out_count=0, out_stall_cycles=0.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-stream discards all in-flight beats and overrides flush.
- Simultaneous in_flush and in_flush_mask: the union applies.
- STAGES=1: single register; out_count is 1 bit wide.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=0xDEAD -> in_ready=0, out_valid=0, out_data=0, out_count=0; after release, in_ready=1.
- Streaming (STAGES=3, out_ready=1): push 0x10..0x14 back-to-back -> in_ready stays 1; 0x10 appears 3 cycles after its offer; then 0x11..0x14 on consecutive cycles; out_count settles at 3.
- Backpressure: out_ready=0, offer A,B,C,D -> A,B,C accepted; in_ready=0 while D is held; out_count=3; out_stall_cycles increments each stalled cycle. Raise out_ready -> A,B,C,D delivered in order, no duplicates.
- Bubble collapse: out_ready=0, push A, idle 2 cycles, push B -> out_count=2 with A in stage 2 and B in stage 1; drain gives A then B on consecutive cycles.
- Selective flush: stages hold C,B,A (A at output), out_ready=1, in_valid=0, in_flush_mask=3'b010 for one cycle -> A delivered that cycle, C squashed, B delivered next cycle; out_count 3->1->0.
- Full flush + saturation: in_flush=1 with in_valid=1 -> in_ready=0 and the beat is not accepted; next cycle out_valid=0, out_count=0. Separately, hold one beat stalled for 70000 cycles (CNT_W=16) -> out_stall_cycles=0xFFFF, no wrap.
